// File: rtl/use_stream_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : use_stream_pkg
// Purpose  : Shared FSM state, keep-mask and width helpers for the USE packer.
// Revision : 1.0
// ============================================================================
package use_stream_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Widest output bus the keep-mask helper can describe.
  localparam int MAX_BUS_BYTES = 64;

  function automatic int cnt_width(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

  function automatic int ch_width(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

  // Low `remaining` bits set, saturating at a full bus of `bus_bytes`.
  function automatic logic [MAX_BUS_BYTES-1:0] keep_mask(input int remaining, input int bus_bytes);
    logic [MAX_BUS_BYTES-1:0] mask;
    mask = '0;
    for (int b = 0; b < MAX_BUS_BYTES; b++) begin
      mask[b] = (b < remaining) && (b < bus_bytes);
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/use_stream_packer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : use_rr_arbiter
// Purpose  : Combinational round-robin pick of the first request at/after ptr.
// Revision : 1.0
// ============================================================================
module use_rr_arbiter
  import use_stream_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  localparam int CH_W = ch_width(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [CH_W-1:0]         ptr,
  output logic [NUM_CHANNELS-1:0] grant,
  output logic [CH_W-1:0]         grant_idx,
  output logic                    grant_valid
);

  always_comb begin : p_grant
    logic [CH_W-1:0] idx;
    idx         = '0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      idx = CH_W'((int'(ptr) + i) % NUM_CHANNELS);
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/use_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : use_stream_packer
// Purpose  : Round-robin capture of whole USEs, serialised into keep/last beats.
// Revision : 1.0
// ============================================================================
module use_stream_packer
  import use_stream_pkg::*;
#(
  parameter int NUM_CHANNELS      = 4,
  parameter int MAX_ELEMENT_BYTES = 34,
  parameter int DATA_BUS_BYTES    = 8,
  localparam int CNT_W = cnt_width(MAX_ELEMENT_BYTES),
  localparam int CH_W  = ch_width(NUM_CHANNELS)
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [NUM_CHANNELS-1:0][MAX_ELEMENT_BYTES*8-1:0] elem_data,
  input  logic [NUM_CHANNELS-1:0][CNT_W-1:0]             elem_byte_count,
  output logic [NUM_CHANNELS-1:0]                        elem_taken,
  output logic [DATA_BUS_BYTES*8-1:0]                    out_data,
  output logic [DATA_BUS_BYTES-1:0]                      out_keep,
  output logic                                           out_last,
  output logic [CH_W-1:0]                                out_channel,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic                                           err_overlength
);

  localparam int ELEM_W     = MAX_ELEMENT_BYTES * 8;
  localparam int BUS_W      = DATA_BUS_BYTES * 8;
  localparam int BEAT_SHIFT = $clog2(DATA_BUS_BYTES);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ELEMENT_BYTES);
  localparam logic [CNT_W-1:0] BUS_CNT = CNT_W'(DATA_BUS_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CHANNELS - 1);
  localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [ELEM_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              err_q, err_d;

  logic [NUM_CHANNELS-1:0] req;
  logic [NUM_CHANNELS-1:0] grant;
  logic [CH_W-1:0]         grant_idx;
  logic                    grant_valid;
  logic [CNT_W-1:0]        raw_count;
  logic                    overlength;

  logic [CNT_W-1:0]          offset;
  logic [CNT_W-1:0]          remaining;
  logic [BUS_W-1:0]          beat_data;
  logic [DATA_BUS_BYTES-1:0] beat_keep;
  logic                      beat_last;
  logic                      fire;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_req
    assign req[c] = |elem_byte_count[c];
  end

  use_rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_arb (
    .req         (req),
    .ptr         (ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign raw_count  = elem_byte_count[grant_idx];
  assign overlength = (raw_count > MAX_CNT);

  // Beat view of the buffer; bytes past the element end are forced to zero.
  always_comb begin
    offset    = beat_q << BEAT_SHIFT;
    remaining = count_q - offset;
    beat_keep = DATA_BUS_BYTES'(keep_mask(int'(remaining), DATA_BUS_BYTES));
    beat_last = (remaining <= BUS_CNT);
    beat_data = BUS_W'(buf_q >> {offset, 3'b000});
    for (int b = 0; b < DATA_BUS_BYTES; b++) begin
      if (!beat_keep[b]) begin
        beat_data[8*b +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    out_valid      = (state_q == SEND);
    out_data       = out_valid ? beat_data : '0;
    out_keep       = out_valid ? beat_keep : '0;
    out_last       = out_valid & beat_last;
    out_channel    = out_valid ? chan_q : '0;
    err_overlength = err_q;
    // Suppressed during reset so a source never drops an element nobody captured.
    elem_taken     = ((state_q == IDLE) && !reset) ? grant : '0;
    fire           = out_valid & out_ready;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    chan_d  = chan_q;
    buf_d   = buf_q;
    count_d = count_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          buf_d   = elem_data[grant_idx];
          count_d = overlength ? MAX_CNT : raw_count;
          chan_d  = grant_idx;
          beat_d  = '0;
          ptr_d   = (grant_idx == LAST_CH) ? '0 : grant_idx + CH_ONE;
          err_d   = err_q | overlength;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fire) begin
          if (beat_last) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q + CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      chan_q  <= '0;
      buf_q   <= '0;
      count_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      chan_q  <= chan_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_use_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_use_stream_packer
// Purpose  : Directed self-checking bench for use_stream_packer (N=4, 34B, 8B bus).
// Revision : 1.0
// ============================================================================
module tb_use_stream_packer;

  localparam int N    = 4;
  localparam int MAXB = 34;
  localparam int B    = 8;

  logic                    clk;
  logic                    reset;
  logic [N-1:0][MAXB*8-1:0] elem_data;
  logic [N-1:0][5:0]       elem_byte_count;
  logic [N-1:0]            elem_taken;
  logic [B*8-1:0]          out_data;
  logic [B-1:0]            out_keep;
  logic                    out_last;
  logic [1:0]              out_channel;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_overlength;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  int taken_cyc [N];

  logic           s_valid, s_last, s_err;
  logic [B*8-1:0] s_data;
  logic [B-1:0]   s_keep;
  logic [1:0]     s_ch;
  logic [N-1:0]   s_taken;
  logic [N-1:0]   prev_taken;
  logic [15:0]    rdy_pat;
  logic [7:0]     lk;

  use_stream_packer #(
    .NUM_CHANNELS      (N),
    .MAX_ELEMENT_BYTES (MAXB),
    .DATA_BUS_BYTES    (B)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .elem_data       (elem_data),
    .elem_byte_count (elem_byte_count),
    .elem_taken      (elem_taken),
    .out_data        (out_data),
    .out_keep        (out_keep),
    .out_last        (out_last),
    .out_channel     (out_channel),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .err_overlength  (err_overlength)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Sample at the falling edge, then emulate the sources clearing taken counts.
  task automatic tick();
    @(negedge clk);
    cyc_n++;
    s_valid = out_valid;
    s_last  = out_last;
    s_data  = out_data;
    s_keep  = out_keep;
    s_ch    = out_channel;
    s_err   = err_overlength;
    s_taken = elem_taken;
    if (s_taken != '0) begin
      chk("taken_onehot", 128'($countones(s_taken)), 128'd1);
      chk("taken_pulse", 128'(s_taken & prev_taken), 128'd0);
      chk("taken_in_send", 128'(s_valid), 128'd0);
    end
    for (int c = 0; c < N; c++) begin
      if (s_taken[c]) taken_cyc[c] = cyc_n;
    end
    prev_taken = s_taken;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      if (s_taken[c]) elem_byte_count[c] = '0;
    end
  endtask

  task automatic load(input int c, input int n, input int base);
    for (int k = 0; k < MAXB; k++) elem_data[c][8*k +: 8] = 8'(base + k);
    elem_byte_count[c] = 6'(n);
  endtask

  // Receive one element and check every accepted beat against the byte model.
  task automatic recv(input int ch, input int n, input int base, input bit stall,
                      input string tag, output logic [7:0] last_keep);
    int eff, nb, idx, budget, rem;
    bit done, seen;
    logic [B*8-1:0] ed;
    logic [7:0]     ek;
    logic           el;
    logic           pv, pr;
    logic [75:0]    snap;
    eff = (n > MAXB) ? MAXB : n;
    nb  = (eff + B - 1) / B;
    idx = 0; budget = 0; done = 0; seen = 0;
    pv = 1'b0; pr = 1'b1; snap = '0; last_keep = '0;
    while (!done && budget < 80) begin
      out_ready = stall ? rdy_pat[cyc_n % 16] : 1'b1;
      tick();
      budget++;
      if (pv && !pr) begin
        chk({tag, "_stall_hold"}, 128'({s_valid, s_last, s_ch, s_keep, s_data}), 128'(snap));
      end
      if (s_valid) begin
        if (!seen) begin
          chk({tag, "_latency"}, 128'(cyc_n - taken_cyc[ch]), 128'd1);
          seen = 1;
        end
        if (out_ready) begin
          rem = eff - idx * B;
          ed  = '0;
          for (int j = 0; j < B; j++) begin
            if (j < rem) ed[8*j +: 8] = 8'(base + idx * B + j);
          end
          ek = (rem >= B) ? 8'hFF : 8'((1 << rem) - 1);
          el = (rem <= B);
          chk({tag, "_data"}, 128'(s_data), 128'(ed));
          chk({tag, "_keep"}, 128'(s_keep), 128'(ek));
          chk({tag, "_last"}, 128'(s_last), 128'(el));
          chk({tag, "_chan"}, 128'(s_ch), 128'(ch));
          last_keep = s_keep;
          idx++;
          if (s_last) done = 1;
        end
      end
      pv   = s_valid;
      pr   = out_ready;
      snap = {s_valid, s_last, s_ch, s_keep, s_data};
    end
    chk({tag, "_beats"}, 128'(idx), 128'(nb));
    out_ready = 1'b1;
    tick();
    chk({tag, "_bubble"}, 128'(s_valid), 128'd0);
  endtask

  initial begin
    rdy_pat         = 16'b1001_0110_0101_1001;
    reset           = 1'b1;
    out_ready       = 1'b1;
    elem_data       = '0;
    elem_byte_count = '0;
    prev_taken      = '0;
    for (int c = 0; c < N; c++) taken_cyc[c] = -100;

    // All four channels pending while reset is held; release grants 0,1,2,3.
    load(0, 5, 8'hA0);
    load(1, 12, 8'hB0);
    load(2, 16, 8'hC0);
    load(3, 3, 8'hD0);
    tick();
    tick();
    chk("rst_outputs", 128'({s_valid, s_last, s_keep, s_data, s_ch, s_err, s_taken}), 128'd0);
    reset = 1'b0;
    tick();
    chk("rr_first_grant", 128'(s_taken), 128'b0001);
    load(0, 7, 8'hE0);
    recv(0, 5, 8'hA0, 0, "rr_c0", lk);
    recv(1, 12, 8'hB0, 0, "rr_c1", lk);
    recv(2, 16, 8'hC0, 0, "rr_c2", lk);
    recv(3, 3, 8'hD0, 0, "rr_c3", lk);
    recv(0, 7, 8'hE0, 0, "rr_c0_reload", lk);

    // 30-byte element: keep FF,FF,FF,3F.
    load(0, 30, 0);
    recv(0, 30, 0, 0, "len30", lk);
    chk("len30_last_keep", 128'(lk), 128'h3F);

    // 8 then 17 back to back on ch0: exactly one bubble between them.
    load(0, 8, 8'h10);
    tick();
    load(0, 17, 8'h40);
    recv(0, 8, 8'h10, 0, "len8", lk);
    chk("len8_keep", 128'(lk), 128'hFF);
    recv(0, 17, 8'h40, 0, "len17", lk);
    chk("len17_last_keep", 128'(lk), 128'h01);

    // Backpressure during a 31-byte element.
    chk("err_clear", 128'(s_err), 128'd0);
    load(1, 31, 8'h31);
    recv(1, 31, 8'h31, 1, "stall31", lk);
    chk("stall31_last_keep", 128'(lk), 128'h7F);

    // Overlength count clamps to 34 and latches the error.
    load(2, 40, 8'h55);
    recv(2, 40, 8'h55, 0, "over40", lk);
    chk("over40_last_keep", 128'(lk), 128'h03);
    chk("over40_err", 128'(s_err), 128'd1);
    load(3, 4, 0);
    recv(3, 4, 0, 0, "len4", lk);
    chk("err_sticky", 128'(s_err), 128'd1);

    // Reset during beat 2; pointer would favour ch3 without the reset.
    load(0, 30, 0);
    tick();
    tick();
    chk("rst_mid_beat1_valid", 128'(s_valid), 128'd1);
    load(0, 30, 8'h80);
    load(3, 9, 8'h40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_mid_valid", 128'(s_valid), 128'd0);
    chk("rst_mid_err", 128'(s_err), 128'd0);
    chk("rst_mid_grant", 128'(s_taken), 128'b0001);
    recv(0, 30, 8'h80, 0, "post_rst_c0", lk);
    recv(3, 9, 8'h40, 0, "post_rst_c3", lk);
    chk("post_rst_c3_last_keep", 128'(lk), 128'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
